// File: rtl/addsub_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : addsub_vector_checker
// Brief    : Drives a fixed 9-vector table into an external 8-bit adder/
//            subtractor, checks {Cout,Sum} and reports pass/err/first_fail.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_vector_checker #(
    parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] Sum,
    input  logic       Cout,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       Op,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] first_fail
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRIVE  = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [3:0] c_LAST_IDX  = 4'd8;
    localparam logic [3:0] c_NO_FAIL   = 4'hF;
    localparam logic [3:0] c_SETTLE    = 4'(SETTLE_CYCLES);

    logic [2:0] r_state;
    logic [3:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_op;
    logic       r_pass;
    logic [3:0] r_err;
    logic [3:0] r_first;

    logic [7:0] w_vec_a;
    logic [7:0] w_vec_b;
    logic       w_vec_op;
    logic [8:0] w_vec_exp;
    logic       w_mismatch;

    // Vector table: operands plus expected {Cout,Sum}
    always_comb begin
        w_vec_a   = 8'h00;
        w_vec_b   = 8'h00;
        w_vec_op  = 1'b0;
        w_vec_exp = 9'h000;
        case (r_idx)
            4'd0: begin w_vec_a = 8'h00; w_vec_b = 8'h00; w_vec_op = 1'b0; w_vec_exp = {1'b0, 8'h00}; end
            4'd1: begin w_vec_a = 8'h0F; w_vec_b = 8'h01; w_vec_op = 1'b0; w_vec_exp = {1'b0, 8'h10}; end
            4'd2: begin w_vec_a = 8'h0F; w_vec_b = 8'h01; w_vec_op = 1'b1; w_vec_exp = {1'b1, 8'h0E}; end
            4'd3: begin w_vec_a = 8'hF0; w_vec_b = 8'h0F; w_vec_op = 1'b0; w_vec_exp = {1'b0, 8'hFF}; end
            4'd4: begin w_vec_a = 8'hF0; w_vec_b = 8'h0F; w_vec_op = 1'b1; w_vec_exp = {1'b1, 8'hE1}; end
            4'd5: begin w_vec_a = 8'hAA; w_vec_b = 8'h55; w_vec_op = 1'b0; w_vec_exp = {1'b0, 8'hFF}; end
            4'd6: begin w_vec_a = 8'hAA; w_vec_b = 8'h55; w_vec_op = 1'b1; w_vec_exp = {1'b1, 8'h55}; end
            4'd7: begin w_vec_a = 8'hFF; w_vec_b = 8'h01; w_vec_op = 1'b0; w_vec_exp = {1'b1, 8'h00}; end
            4'd8: begin w_vec_a = 8'hFF; w_vec_b = 8'h01; w_vec_op = 1'b1; w_vec_exp = {1'b1, 8'hFE}; end
            default: begin w_vec_a = 8'h00; w_vec_b = 8'h00; w_vec_op = 1'b0; w_vec_exp = 9'h000; end
        endcase
    end

    assign w_mismatch = ({Cout, Sum} != w_vec_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_op    <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_first <= c_NO_FAIL;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_DRIVE;
                        r_idx   <= 4'd0;
                        r_err   <= 4'd0;
                        r_first <= c_NO_FAIL;
                        r_pass  <= 1'b0;
                    end
                end
                c_ST_DRIVE: begin
                    r_a     <= w_vec_a;
                    r_b     <= w_vec_b;
                    r_op    <= w_vec_op;
                    r_cnt   <= c_SETTLE;
                    r_state <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    // Nine vectors bound err_count to 9, so no saturation logic is needed
                    if (w_mismatch) begin
                        r_err <= r_err + 4'd1;
                        if (r_first == c_NO_FAIL) begin
                            r_first <= r_idx;
                        end
                    end
                    if (r_idx < c_LAST_IDX) begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= c_ST_DRIVE;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_pass  <= (r_err == 4'd0);
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign A          = r_a;
    assign B          = r_b;
    assign Op         = r_op;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_first;

endmodule
`default_nettype wire

// File: tb/tb_addsub_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_vector_checker
// Brief    : Scoreboard bench for addsub_vector_checker (SETTLE 1 and 3) with
//            a behavioural adder/subtractor that can inject faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_vector_checker;

    typedef struct {
        logic [3:0] err;
        logic [3:0] ff;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [7:0] sum1, a1, b1, sum3, a3, b3;
    logic       cout1, op1, busy1, done1, pass1;
    logic       cout3, op3, busy3, done3, pass3;
    logic [3:0] err1, ff1, err3, ff3;

    int         mode1 = 0;
    int         mode3 = 0;
    logic [8:0] mask1 = '0;
    logic [8:0] mask3 = '0;

    exp_t q1[$];
    exp_t q3[$];

    int n_assert   = 0;
    int n_fail     = 0;
    int to_cnt     = 0;
    bit finish_req = 1'b0;

    int e_cnt[2];
    bit run_on[2];
    bit pass_due[2];
    bit exp_pass[2];
    bit acc_due[2];

    logic [7:0] ta [9] = '{8'h00, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'hAA, 8'hAA, 8'hFF, 8'hFF};
    logic [7:0] tbv[9] = '{8'h00, 8'h01, 8'h01, 8'h0F, 8'h0F, 8'h55, 8'h55, 8'h01, 8'h01};
    logic       top[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    addsub_vector_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .Sum(sum1), .Cout(cout1),
        .A(a1), .B(b1), .Op(op1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    addsub_vector_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .Sum(sum3), .Cout(cout3),
        .A(a3), .B(b3), .Op(op3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3)
    );

    // Golden arithmetic: add, or subtract as A + ~B + 1 in 9 bits
    function automatic logic [8:0] ref_out(input logic [7:0] a, input logic [7:0] b, input logic op);
        if (op) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Unit under test: 0 good, 1 Cout stuck 0, 2 subtract acts as add, 3 Sum[0] flipped on masked vectors
    function automatic logic [8:0] model_out(input logic [7:0] a, input logic [7:0] b, input logic op,
                                             input int mode, input logic [8:0] mask);
        logic [8:0] r;
        r = ref_out(a, b, op);
        case (mode)
            1: r[8] = 1'b0;
            2: r = {1'b0, a} + {1'b0, b};
            3: for (int i = 0; i < 9; i++)
                   if (ta[i] == a && tbv[i] == b && top[i] == op && mask[i]) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout1, sum1} = model_out(a1, b1, op1, mode1, mask1);
    always_comb {cout3, sum3} = model_out(a3, b3, op3, mode3, mask3);

    function automatic exp_t expect_run(input int mode, input logic [8:0] mask);
        exp_t x;
        x.err = 4'd0;
        x.ff  = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (model_out(ta[i], tbv[i], top[i], mode, mask) != ref_out(ta[i], tbv[i], top[i])) begin
                x.err = x.err + 4'd1;
                if (x.ff == 4'hF) x.ff = 4'(i);
            end
        end
        return x;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic mon(input int k, input int s, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic bsy, input logic dn, input logic ps,
                       input logic [3:0] err, input logic [3:0] ff, input logic st);
        int   len;
        int   idx;
        int   depth;
        exp_t x;
        len = 9 * (s + 2);
        if (!rst_n) begin
            chk("reset_A", k, a, 0);       chk("reset_B", k, b, 0);
            chk("reset_Op", k, op, 0);     chk("reset_busy", k, bsy, 0);
            chk("reset_done", k, dn, 0);   chk("reset_pass", k, ps, 0);
            chk("reset_err", k, err, 0);   chk("reset_ff", k, ff, 4'hF);
            run_on[k] = 1'b0; pass_due[k] = 1'b0; acc_due[k] = 1'b0;
            return;
        end
        if (pass_due[k]) begin
            chk("pass_after_done", k, ps, exp_pass[k]);
            pass_due[k] = 1'b0;
        end
        if (acc_due[k]) begin
            chk("start_accept", k, bsy, 1);
            acc_due[k] = 1'b0;
        end
        acc_due[k] = !bsy && st;
        if (bsy) begin
            if (!run_on[k]) begin
                run_on[k] = 1'b1;
                e_cnt[k]  = 0;
                chk("run_clear_pass", k, ps, 0);
                chk("run_clear_err", k, err, 0);
                chk("run_clear_ff", k, ff, 4'hF);
            end else begin
                e_cnt[k]++;
            end
            if (e_cnt[k] >= 1) begin
                idx = (e_cnt[k] - 1) / (s + 2);
                if (idx > 8) idx = 8;
                chk("vec_A", k, a, ta[idx]);
                chk("vec_B", k, b, tbv[idx]);
                chk("vec_Op", k, op, top[idx]);
            end
            chk("done_timing", k, dn, (e_cnt[k] == len));
            if (dn) begin
                depth = (k == 0) ? q1.size() : q3.size();
                chk("sb_pending", k, (depth > 0), 1);
                if (depth > 0) begin
                    x = (k == 0) ? q1.pop_front() : q3.pop_front();
                    chk("err_count", k, err, x.err);
                    chk("first_fail", k, ff, x.ff);
                    exp_pass[k] = (x.err == 4'd0);
                    pass_due[k] = 1'b1;
                end
                run_on[k] = 1'b0;
            end
        end else begin
            chk("done_idle", k, dn, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, a1, b1, op1, busy1, done1, pass1, err1, ff1, start1);
        mon(1, 3, a3, b3, op3, busy3, done3, pass3, err3, ff3, start3);
        if (finish_req) begin
            chk("sb_empty", 0, q1.size(), 0);
            chk("sb_empty", 1, q3.size(), 0);
            chk("wait_timeouts", 0, to_cnt, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
            $finish;
        end
    end

    task automatic wait_idle(input int k);
        for (int i = 0; i < 400; i++) begin
            if (((k == 0) ? busy1 : busy3) == 1'b0) return;
            @(posedge clk); #1;
        end
        to_cnt++;
    endtask

    task automatic run_once(input int k, input int mode, input logic [8:0] mask, input bit extra);
        wait_idle(k);
        if (k == 0) begin
            mode1 = mode; mask1 = mask; q1.push_back(expect_run(mode, mask)); start1 = 1'b1;
        end else begin
            mode3 = mode; mask3 = mask; q3.push_back(expect_run(mode, mask)); start3 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        if (extra) begin
            repeat ($urandom_range(2, 20)) @(posedge clk);
            #1;
            if (k == 0) start1 = 1'b1; else start3 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0; start3 = 1'b0;
        end
        wait_idle(k);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_once(0, 0, 9'h000, 1'b1);
        run_once(0, 1, 9'h000, 1'b0);
        run_once(0, 2, 9'h000, 1'b0);
        for (int r = 0; r < 6; r++)
            run_once(0, int'($urandom_range(0, 3)), 9'($urandom), ($urandom_range(0, 1) == 1));

        // Abort during vector 4's settle, with a stray start while busy
        wait_idle(0);
        mode1 = 0; mask1 = '0;
        q1.push_back(expect_run(0, 9'h000));
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_once(0, 0, 9'h000, 1'b0);

        // Start held high across two runs
        wait_idle(0);
        mode1 = int'($urandom_range(0, 3)); mask1 = 9'($urandom);
        q1.push_back(expect_run(mode1, mask1));
        q1.push_back(expect_run(mode1, mask1));
        start1 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200 && busy1; i++) begin
            @(posedge clk); #1;
        end
        if (busy1) to_cnt++;
        @(posedge clk); #1 start1 = 1'b0;
        wait_idle(0);

        run_once(1, 0, 9'h000, 1'b0);
        run_once(1, int'($urandom_range(1, 3)), 9'($urandom), 1'b1);

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge clk);
        #1 finish_req = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
